// File: rtl/risc_sequencer_if.sv
// Core-side bus between the program sequencer and the RISC core.
// The sequencer drives the issued instruction; the core returns result flags.
interface risc_sequencer_if;
    logic [3:0]  opcode;
    logic [3:0]  operand_1;
    logic [7:0]  operand_2;
    logic        issue_valid;
    logic [15:0] alu_result;
    logic        cb;

    modport master (
        output opcode,
        output operand_1,
        output operand_2,
        output issue_valid,
        input  alu_result,
        input  cb
    );

    modport slave (
        input  opcode,
        input  operand_1,
        input  operand_2,
        input  issue_valid,
        output alu_result,
        output cb
    );
endinterface

// File: rtl/risc_sequencer.sv
// Program sequencer: host-loaded program memory, fetch/decode/issue,
// fixed execute latency, local control flow (halt, jmp, jz, jc).
module risc_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int PROG_DEPTH  = 16,
    parameter int EXEC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data,
    risc_sequencer_if.master  core,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic [15:0]       retired_count,
    output logic              ld_err
);

    localparam logic [3:0] CTRL_OP = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WAIT,
        S_HALTED
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [15:0]       mem [PROG_DEPTH];
    logic [15:0]       ir;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] pc_n;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] tgt;
    logic              do_start;
    logic              do_issue;
    logic              do_retire;

    assign busy   = (state == S_FETCH) || (state == S_DECODE) || (state == S_WAIT);
    assign done   = (state == S_HALTED);
    assign pc_inc = pc + ADDR_W'(1);
    assign tgt    = ir[ADDR_W-1:0];

    // Program memory write port; loads are refused while a program runs.
    always_ff @(posedge clk) begin
        if (ld_en && !busy) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, next pc and the datapath strobes; abort overrides everything.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        do_start  = 1'b0;
        do_issue  = 1'b0;
        do_retire = 1'b0;
        if (abort) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state_n  = S_FETCH;
                        pc_n     = '0;
                        do_start = 1'b1;
                    end
                end
                S_FETCH: begin
                    state_n = S_DECODE;
                end
                S_DECODE: begin
                    if (ir[15:12] == CTRL_OP) begin
                        state_n = S_FETCH;
                        unique case (ir[11:8])
                            4'd1:    pc_n = tgt;
                            4'd2:    pc_n = zero_flag ? tgt : pc_inc;
                            4'd3:    pc_n = carry_flag ? tgt : pc_inc;
                            default: state_n = S_HALTED;
                        endcase
                    end else begin
                        do_issue = 1'b1;
                        state_n  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt <= 4'd1) begin
                        do_retire = 1'b1;
                        pc_n      = pc_inc;
                        state_n   = S_FETCH;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // Datapath: instruction register, issue outputs, wait counter, flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc               <= '0;
            ir               <= '0;
            cnt              <= '0;
            core.opcode      <= '0;
            core.operand_1   <= '0;
            core.operand_2   <= '0;
            core.issue_valid <= 1'b0;
            zero_flag        <= 1'b0;
            carry_flag       <= 1'b0;
            retired_count    <= '0;
            ld_err           <= 1'b0;
        end else begin
            pc               <= pc_n;
            core.issue_valid <= do_issue;
            ld_err           <= ld_en && busy;
            if (state == S_FETCH) begin
                ir <= mem[pc];
            end
            if (do_start) begin
                zero_flag     <= 1'b0;
                carry_flag    <= 1'b0;
                retired_count <= '0;
            end
            if (do_issue) begin
                core.opcode    <= ir[15:12];
                core.operand_1 <= ir[11:8];
                core.operand_2 <= ir[7:0];
                cnt            <= 4'(EXEC_CYCLES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (do_retire) begin
                zero_flag  <= (core.alu_result == 16'h0000);
                carry_flag <= core.cb;
                if (retired_count != 16'hFFFF) begin
                    retired_count <= retired_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_risc_sequencer.sv
// Directed bench for risc_sequencer: a program-level interpreter predicts
// every output cycle by cycle after each start; literal checks pin it.
module tb_risc_sequencer;

    localparam int LIM = 64;
    localparam int E   = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;
    logic        busy;
    logic        done;
    logic [3:0]  pc;
    logic        zero_flag;
    logic        carry_flag;
    logic [15:0] retired_count;
    logic        ld_err;
    logic [15:0] alu_val;
    logic        cb_val;

    risc_sequencer_if bus ();

    assign bus.alu_result = alu_val;
    assign bus.cb         = cb_val;

    risc_sequencer #(
        .ADDR_W(4),
        .PROG_DEPTH(16),
        .EXEC_CYCLES(E)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .ld_en(ld_en),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .core(bus.master),
        .busy(busy),
        .done(done),
        .pc(pc),
        .zero_flag(zero_flag),
        .carry_flag(carry_flag),
        .retired_count(retired_count),
        .ld_err(ld_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Shadow of program memory and the predicted per-cycle outputs.
    logic [15:0] mm [16];
    bit          e_busy [LIM];
    bit          e_done [LIM];
    bit          e_iv   [LIM];
    bit          e_z    [LIM];
    bit          e_c    [LIM];
    logic [3:0]  e_pc   [LIM];
    logic [15:0] e_word [LIM];
    logic [15:0] e_cnt  [LIM];
    logic [15:0] last_issue = 16'h0000;
    bit          active = 1'b0;
    int          t0 = 0;

    task automatic put(int k, bit b, bit d, logic [3:0] p, bit iv,
                       logic [15:0] w, bit z, bit cy, logic [15:0] n);
        if (k < LIM) begin
            e_busy[k] = b;
            e_done[k] = d;
            e_pc[k]   = p;
            e_iv[k]   = iv;
            e_word[k] = w;
            e_z[k]    = z;
            e_c[k]    = cy;
            e_cnt[k]  = n;
        end
    endtask

    // Interpret the program: control words take 2 cycles, core words 2+E.
    task automatic build_model();
        int          c = 0;
        logic [3:0]  p = 4'd0;
        bit          z = 1'b0;
        bit          cy = 1'b0;
        bit          halted = 1'b0;
        logic [15:0] n = 16'd0;
        logic [15:0] w;
        logic [15:0] last;
        last = last_issue;
        while (c < LIM && !halted) begin
            w = mm[p];
            put(c, 1, 0, p, 0, last, z, cy, n);
            put(c + 1, 1, 0, p, 0, last, z, cy, n);
            if (w[15:12] == 4'hF) begin
                c += 2;
                case (w[11:8])
                    4'd1:    p = w[3:0];
                    4'd2:    p = z ? w[3:0] : p + 4'd1;
                    4'd3:    p = cy ? w[3:0] : p + 4'd1;
                    default: halted = 1'b1;
                endcase
            end else begin
                last = w;
                for (int j = 0; j < E; j++) begin
                    put(c + 2 + j, 1, 0, p, (j == 0), last, z, cy, n);
                end
                z  = (alu_val == 16'h0000);
                cy = cb_val;
                if (n != 16'hFFFF) n = n + 16'd1;
                p  = p + 4'd1;
                c += 2 + E;
            end
        end
        for (int k = c; k < LIM; k++) begin
            put(k, 0, 1, p, 0, last, z, cy, n);
        end
    endtask

    // Cycle-by-cycle comparison against the interpreter.
    always @(negedge clk) begin
        int k;
        if (active) begin
            k = cyc - t0;
            if (k >= 0 && k < LIM) begin
                chk("busy", busy, e_busy[k]);
                chk("done", done, e_done[k]);
                chk("pc", pc, e_pc[k]);
                chk("issue_valid", bus.issue_valid, e_iv[k]);
                chk("issued_word", {bus.opcode, bus.operand_1, bus.operand_2}, e_word[k]);
                chk("zero_flag", zero_flag, e_z[k]);
                chk("carry_flag", carry_flag, e_c[k]);
                chk("retired_count", retired_count, e_cnt[k]);
            end
        end
    end

    function automatic int cur_k();
        int k;
        k = cyc - t0;
        if (k > LIM - 1) k = LIM - 1;
        if (k < 0) k = 0;
        return k;
    endfunction

    task automatic load(logic [3:0] a, logic [15:0] d);
        @(negedge clk);
        #2;
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        mm[a]   = d;
        @(negedge clk);
        #2;
        ld_en = 1'b0;
    endtask

    // Returns 2 time units after the negedge of the first FETCH cycle (k=0).
    task automatic go();
        @(negedge clk);
        #2;
        if (active) last_issue = e_word[cur_k()];
        t0    = cyc + 1;
        start = 1'b1;
        build_model();
        active = 1'b1;
        @(negedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_neg(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int          iss [$];
        int          lerr;
        int          kk;
        logic [15:0] exp_cnt;

        rst     = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        ld_en   = 1'b0;
        ld_addr = 4'd0;
        ld_data = 16'h0000;
        alu_val = 16'h0000;
        cb_val  = 1'b0;

        wait_neg(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pc", pc, 0);
        chk("rst_word", {bus.opcode, bus.operand_1, bus.operand_2}, 0);
        chk("rst_iv", bus.issue_valid, 0);
        chk("rst_flags", {zero_flag, carry_flag}, 0);
        chk("rst_count", retired_count, 0);
        chk("rst_lderr", ld_err, 0);
        #2;
        rst = 1'b1;

        for (int i = 0; i < 16; i++) load(4'(i), 16'hF000);

        // Basic issue, retire and halt.
        load(4'd0, 16'h1203);
        alu_val = 16'h0005;
        cb_val  = 1'b0;
        go();
        wait_neg(2);
        chk("t1_iv", bus.issue_valid, 1);
        chk("t1_word", {bus.opcode, bus.operand_1, bus.operand_2}, 16'h1203);
        wait_neg(2);
        chk("t1_zero", zero_flag, 0);
        chk("t1_count", retired_count, 1);
        chk("t1_pc", pc, 1);
        wait_neg(2);
        chk("t1_done", done, 1);
        wait_neg(3);

        // Load during WAIT: refused, single ld_err pulse.
        go();
        wait_neg(2);
        chk("lderr_k2", ld_err, 0);
        #2;
        ld_en   = 1'b1;
        ld_addr = 4'd0;
        ld_data = 16'hF000;
        @(negedge clk);
        chk("lderr_k3", ld_err, 1);
        #2;
        ld_en = 1'b0;
        lerr  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ld_err) lerr++;
        end
        chk("lderr_extra", lerr, 0);
        chk("lderr_halted", done, 1);
        go();
        wait_neg(2);
        chk("mem_kept_iv", bus.issue_valid, 1);
        chk("mem_kept_word", {bus.opcode, bus.operand_1, bus.operand_2}, 16'h1203);
        wait_neg(6);

        // Abort and start together on the retiring WAIT cycle.
        cb_val = 1'b1;
        go();
        wait_neg(3);
        #2;
        abort      = 1'b1;
        start      = 1'b1;
        last_issue = e_word[cur_k()];
        active     = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_iv", bus.issue_valid, 0);
        chk("abort_count", retired_count, 0);
        chk("abort_carry", carry_flag, 0);
        chk("abort_pc", pc, 0);
        #2;
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("abort_idle", busy, 0);
        cb_val = 1'b0;

        // Asynchronous reset during FETCH.
        go();
        #1;
        rst        = 1'b0;
        active     = 1'b0;
        last_issue = 16'h0000;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_pc", pc, 0);
        chk("arst_word", {bus.opcode, bus.operand_1, bus.operand_2}, 0);
        chk("arst_iv", bus.issue_valid, 0);
        chk("arst_flags", {zero_flag, carry_flag}, 0);
        chk("arst_count", retired_count, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        go();
        wait_neg(2);
        chk("arst_run_iv", bus.issue_valid, 1);
        wait_neg(6);
        chk("arst_run_done", done, 1);

        // JZ taken / not taken, JC taken; start while busy is ignored.
        load(4'd0, 16'h3012);
        load(4'd1, 16'hF205);
        load(4'd5, 16'hF000);
        alu_val = 16'h0000;
        go();
        #1;
        start = 1'b1;
        @(negedge clk);
        #2;
        start = 1'b0;
        wait_neg(9);
        chk("jz_taken_done", done, 1);
        chk("jz_taken_pc", pc, 5);
        alu_val = 16'h0001;
        go();
        wait_neg(10);
        chk("jz_not_done", done, 1);
        chk("jz_not_pc", pc, 2);
        load(4'd1, 16'hF305);
        cb_val = 1'b1;
        go();
        wait_neg(10);
        chk("jc_taken_pc", pc, 5);
        chk("jc_carry", carry_flag, 1);
        cb_val = 1'b0;
        load(4'd1, 16'hF000);

        // PC wrap: JMP 15, core word at 15, back to 0 forever.
        load(4'd0, 16'hF10F);
        load(4'd15, 16'h2A55);
        alu_val = 16'h0010;
        go();
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.issue_valid) iss.push_back(cyc - t0);
        end
        chk("wrap_issues", iss.size(), 7);
        if (iss.size() > 0) chk("wrap_first", iss[0], 4);
        for (int i = 1; i < iss.size(); i++) begin
            chk("wrap_period", iss[i] - iss[i-1], 6);
        end
        #2;
        kk         = cur_k();
        exp_cnt    = e_cnt[kk];
        last_issue = e_word[kk];
        active     = 1'b0;
        abort      = 1'b1;
        @(negedge clk);
        chk("wrap_abort_busy", busy, 0);
        chk("wrap_abort_count", retired_count, exp_cnt);
        chk("wrap_count_lit", retired_count, 6);
        #2;
        abort = 1'b0;
        wait_neg(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc_sequencer.md
Name: risc_sequencer

Overview:
- Program sequencer in front of the RISC core; replaces the manual opcode/operand_1/operand_2 drive.
- Holds a small host-loaded program memory and a program counter.
- Fetches and decodes each instruction, then issues it to the core and waits a fixed execute latency.
- Samples alu_op/cb as retired result flags; executes its own control opcodes (halt, jump, jump-on-zero, jump-on-carry) without issuing them to the core.

Parameters:
- ADDR_W, 4: program address width.
- PROG_DEPTH, 16: program words, must equal 2**ADDR_W.
- EXEC_CYCLES, 2: cycles from issue until the core's alu_op/cb are valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin execution at PC=0; accepted only in IDLE or HALTED.
- abort  in  1  force return to IDLE from any state.
- ld_en  in  1  program-load write strobe.
- ld_addr  in  ADDR_W  program-load address.
- ld_data  in  16  program word: [15:12] opcode, [11:8] operand_1, [7:0] operand_2.
- alu_result  in  16  core alu_op.
- cb  in  1  core carry/borrow.
- opcode  out  4  instruction opcode to the core.
- operand_1  out  4  to the core.
- operand_2  out  8  to the core.
- issue_valid  out  1  one-cycle pulse when opcode/operands present a new instruction.
- busy  out  1  high in FETCH/DECODE/WAIT.
- done  out  1  high in HALTED.
- pc  out  ADDR_W  current program counter.
- zero_flag  out  1  last retired alu_result==0.
- carry_flag  out  1  last retired cb.
- retired_count  out  16  number of core instructions retired, saturating.
- ld_err  out  1  one-cycle pulse when ld_en arrives while busy.

Behaviour:
- Reset (rst=0, async): state IDLE; pc=0; opcode/operand_1/operand_2=0; issue_valid/busy/done/ld_err=0; flags=0; retired_count=0. Program memory is not cleared.
- Load: ld_en in IDLE or HALTED writes ld_data to mem[ld_addr] at the clock edge. ld_en while busy performs no write and pulses ld_err the next cycle.
- Core-side outputs are registered. opcode/operands hold their last issued value between issues.
- IDLE: start -> pc=0, flags cleared, retired_count cleared, go to FETCH.
- FETCH (1 cycle): ir <= mem[pc]. A load and a start at the same edge is legal; the fetch sees the new word.
- DECODE (1 cycle): opcode 4'hF is a sequencer control instruction and is never issued. operand_1 selects the action; T = operand_2[ADDR_W-1:0]:
  - 0 HALT: go to HALTED, pc unchanged.
  - 1 JMP: pc=T, go to FETCH.
  - 2 JZ: pc = zero_flag ? T : pc+1, go to FETCH.
  - 3 JC: pc = carry_flag ? T : pc+1, go to FETCH.
  - Any other operand_1: treated as HALT.
- DECODE, any opcode other than 4'hF: drive opcode/operands from ir, pulse issue_valid, load wait counter with EXEC_CYCLES, go to WAIT.
- WAIT: counter decrements each cycle. On the cycle it reaches 0:
  - zero_flag <= (alu_result==16'h0); carry_flag <= cb.
  - retired_count increments, saturating at 16'hFFFF.
  - pc <= pc+1 modulo PROG_DEPTH, so pc=PROG_DEPTH-1 wraps to 0.
  - Go to FETCH.
- Latency: core instruction = 2+EXEC_CYCLES cycles; control instruction = 2 cycles.
- HALTED: done=1, busy=0. start restarts exactly as from IDLE.
- abort: any state -> IDLE at the next edge; issue_valid=0; flags and count retained. Abort has priority over start.
- start while busy: ignored.
- Reset asserted mid-WAIT: immediate return to the reset values; no retirement occurs.

Test Plan:
- Load mem[0]=16'h1203, mem[1]=16'hF000, EXEC_CYCLES=2, start:
  - issue_valid pulses 2 cycles after start, with opcode=1, operand_1=2, operand_2=8'h03.
  - Drive alu_result=16'h0005; it is retired 2 cycles later: zero_flag=0, retired_count=1, pc=1.
  - done=1 two cycles after the retire.
- JZ taken/not-taken: mem[0]=core instruction, mem[1]=16'hF205, mem[5]=HALT.
  - alu_result=0 -> halts at pc=5.
  - alu_result=16'h0001 -> pc goes to 2.
- Wrap-around: mem[15]=core instruction, start via mem[0]=16'hF10F (JMP 15).
  - After retiring mem[15], pc=0 and the JMP re-executes. Verify issue_valid repeats every 6 cycles (2 for the JMP, 4 for the core instruction).
- ld_en during WAIT: memory is unchanged (read back after halt), and ld_err pulses exactly once.
- abort and start asserted together in WAIT: IDLE next cycle; no retirement; retired_count unchanged.
- Async reset pulse mid-FETCH: all outputs return to their reset values without a clock edge; the program still runs correctly after release and start.
